// File: rtl/wb_bfm_pkg.sv
// Shared definitions for the passive Wishbone protocol checker: FSM states,
// violation codes, cycle/burst type encodings and the violation priority encoder.
package wb_bfm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_BURST  = 2'd2
    } state_t;

    localparam logic [3:0] CODE_NONE       = 4'd0;
    localparam logic [3:0] CODE_STB_NO_CYC = 4'd1;
    localparam logic [3:0] CODE_UNSTABLE   = 4'd2;
    localparam logic [3:0] CODE_MULTI_TERM = 4'd3;
    localparam logic [3:0] CODE_STRAY_TERM = 4'd4;
    localparam logic [3:0] CODE_BURST_ADR  = 4'd5;
    localparam logic [3:0] CODE_TIMEOUT    = 4'd6;
    localparam logic [3:0] CODE_BURST_CTI  = 4'd7;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    // Bit i of viol stands for code i+1; the lowest set code wins.
    function automatic logic [3:0] first_code(input logic [6:0] viol);
        if (viol[0])      return CODE_STB_NO_CYC;
        else if (viol[1]) return CODE_UNSTABLE;
        else if (viol[2]) return CODE_MULTI_TERM;
        else if (viol[3]) return CODE_STRAY_TERM;
        else if (viol[4]) return CODE_BURST_ADR;
        else if (viol[5]) return CODE_TIMEOUT;
        else if (viol[6]) return CODE_BURST_CTI;
        else              return CODE_NONE;
    endfunction

endpackage

// File: rtl/wb_bfm_next_adr.sv
// Next expected address of an incrementing burst: linear, or wrapping over
// 4/8/16 beats with the bits above the wrap boundary held.
module wb_bfm_next_adr
    import wb_bfm_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic [AW-1:0] adr,
    input  logic [2:0]    cti,
    input  logic [1:0]    bte,
    output logic [AW-1:0] next_adr
);
    localparam int BPW = DW / 8;
    localparam logic [AW-1:0] STEP = AW'(BPW);

    logic [AW-1:0] inc_s;
    logic [AW-1:0] mask_s;

    // Wrap mask selects which low bits advance; linear uses all bits.
    always_comb begin
        inc_s = adr + STEP;
        case (bte)
            BTE_WRAP4:  mask_s = AW'(4 * BPW - 1);
            BTE_WRAP8:  mask_s = AW'(8 * BPW - 1);
            BTE_WRAP16: mask_s = AW'(16 * BPW - 1);
            default:    mask_s = {AW{1'b1}};
        endcase
        if (cti == CTI_INCR) begin
            next_adr = (adr & ~mask_s) | (inc_s & mask_s);
        end else begin
            next_adr = adr;
        end
    end

endmodule

// File: rtl/wb_bfm_checker.sv
// Passive Wishbone bus monitor: flags protocol violations with a registered
// pulse/code/address and keeps beat, burst and violation statistics.
module wb_bfm_checker
    import wb_bfm_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 256
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic [AW-1:0]   wb_adr_i,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic [DW/8-1:0] wb_sel_i,
    input  logic            wb_we_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic [2:0]      wb_cti_i,
    input  logic [1:0]      wb_bte_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    input  logic            wb_rty_i,
    output logic            err_o,
    output logic [3:0]      err_code_o,
    output logic [AW-1:0]   err_adr_o,
    output logic [7:0]      err_cnt_o,
    output logic [15:0]     rd_cnt_o,
    output logic [15:0]     wr_cnt_o,
    output logic [15:0]     burst_cnt_o
);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(TIMEOUT);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    state_t          state_r, state_nxt_s;
    logic [AW-1:0]   exp_adr_r, next_adr_s;
    logic [WW-1:0]   wait_r, wait_nxt_s;
    logic [AW-1:0]   prev_adr_r;
    logic [DW-1:0]   prev_dat_r;
    logic [DW/8-1:0] prev_sel_r;
    logic            prev_we_r;
    logic [2:0]      prev_cti_r;
    logic [1:0]      prev_bte_r;
    logic            prev_hold_r;
    logic            armed_r;
    logic            strobe_s, term_s, ack_ok_s, stall_s, changed_s, cti_rsvd_s;
    logic [6:0]      viol_s;

    logic            err_r;
    logic [3:0]      err_code_r;
    logic [AW-1:0]   err_adr_r;
    logic [7:0]      err_cnt_r;
    logic [15:0]     rd_cnt_r, wr_cnt_r, burst_cnt_r;

    wb_bfm_next_adr #(.AW(AW), .DW(DW)) u_next_adr (
        .adr      (wb_adr_i),
        .cti      (wb_cti_i),
        .bte      (wb_bte_i),
        .next_adr (next_adr_s)
    );

    // Decode the current bus sample into violation flags.
    always_comb begin
        strobe_s   = wb_cyc_i & wb_stb_i;
        term_s     = wb_ack_i | wb_err_i | wb_rty_i;
        ack_ok_s   = strobe_s & wb_ack_i & ~wb_err_i & ~wb_rty_i;
        stall_s    = strobe_s & ~term_s;
        cti_rsvd_s = (wb_cti_i >= 3'b011) && (wb_cti_i <= 3'b110);
        changed_s  = (wb_adr_i != prev_adr_r) | (wb_we_i != prev_we_r) |
                     (wb_sel_i != prev_sel_r) | (wb_cti_i != prev_cti_r) |
                     (wb_bte_i != prev_bte_r) | (wb_we_i & (wb_dat_i != prev_dat_r));
        viol_s[0]  = wb_stb_i & ~wb_cyc_i;
        viol_s[1]  = prev_hold_r & strobe_s & changed_s;
        viol_s[2]  = (wb_ack_i & wb_err_i) | (wb_ack_i & wb_rty_i) | (wb_err_i & wb_rty_i);
        viol_s[3]  = term_s & ~strobe_s;
        viol_s[4]  = (state_r == ST_BURST) & strobe_s & (wb_adr_i != exp_adr_r);
        viol_s[5]  = stall_s & (wait_r == WAIT_LAST);
        viol_s[6]  = armed_r & (((state_r == ST_BURST) & ~wb_cyc_i) | (strobe_s & cti_rsvd_s));
        if (!stall_s) begin
            wait_nxt_s = '0;
        end else if (wait_r == WAIT_MAX) begin
            wait_nxt_s = wait_r;
        end else begin
            wait_nxt_s = wait_r + {{(WW-1){1'b0}}, 1'b1};
        end
    end

    // Next state: an IDLE sample with cyc high is judged as ACTIVE so a
    // burst may open on the very first beat of a cycle.
    always_comb begin
        state_nxt_s = state_r;
        if (!wb_cyc_i) begin
            state_nxt_s = ST_IDLE;
        end else if (state_r != ST_BURST) begin
            if (ack_ok_s && (wb_cti_i == CTI_INCR)) begin
                state_nxt_s = ST_BURST;
            end else begin
                state_nxt_s = ST_ACTIVE;
            end
        end else begin
            if (strobe_s && (wb_err_i || wb_rty_i)) begin
                state_nxt_s = ST_ACTIVE;
            end else if (ack_ok_s && (wb_cti_i == CTI_END)) begin
                state_nxt_s = ST_ACTIVE;
            end else begin
                state_nxt_s = ST_BURST;
            end
        end
    end

    // FSM, burst address tracking and previous-sample capture.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_r     <= ST_IDLE;
            exp_adr_r   <= '0;
            wait_r      <= '0;
            prev_adr_r  <= '0;
            prev_dat_r  <= '0;
            prev_sel_r  <= '0;
            prev_we_r   <= 1'b0;
            prev_cti_r  <= 3'b000;
            prev_bte_r  <= 2'b00;
            prev_hold_r <= 1'b0;
            armed_r     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            wait_r      <= wait_nxt_s;
            prev_adr_r  <= wb_adr_i;
            prev_dat_r  <= wb_dat_i;
            prev_sel_r  <= wb_sel_i;
            prev_we_r   <= wb_we_i;
            prev_cti_r  <= wb_cti_i;
            prev_bte_r  <= wb_bte_i;
            prev_hold_r <= stall_s;
            armed_r     <= 1'b1;
            if (ack_ok_s && (state_nxt_s == ST_BURST)) begin
                exp_adr_r <= next_adr_s;
            end else begin
                exp_adr_r <= exp_adr_r;
            end
        end
    end

    // Violation report and transfer statistics.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            err_r       <= 1'b0;
            err_code_r  <= CODE_NONE;
            err_adr_r   <= '0;
            err_cnt_r   <= 8'd0;
            rd_cnt_r    <= 16'd0;
            wr_cnt_r    <= 16'd0;
            burst_cnt_r <= 16'd0;
        end else begin
            err_r <= |viol_s;
            if (|viol_s) begin
                err_code_r <= first_code(viol_s);
                err_adr_r  <= wb_adr_i;
                err_cnt_r  <= (err_cnt_r == 8'd255) ? err_cnt_r : err_cnt_r + 8'd1;
            end else begin
                err_code_r <= err_code_r;
                err_adr_r  <= err_adr_r;
                err_cnt_r  <= err_cnt_r;
            end
            rd_cnt_r    <= rd_cnt_r + {15'd0, ack_ok_s & ~wb_we_i};
            wr_cnt_r    <= wr_cnt_r + {15'd0, ack_ok_s & wb_we_i};
            burst_cnt_r <= burst_cnt_r +
                           {15'd0, (state_r == ST_BURST) & ack_ok_s & (wb_cti_i == CTI_END)};
        end
    end

    assign err_o       = err_r;
    assign err_code_o  = err_code_r;
    assign err_adr_o   = err_adr_r;
    assign err_cnt_o   = err_cnt_r;
    assign rd_cnt_o    = rd_cnt_r;
    assign wr_cnt_o    = wr_cnt_r;
    assign burst_cnt_o = burst_cnt_r;

endmodule

// File: tb/tb_wb_bfm_checker.sv
// Directed bench for wb_bfm_checker: expected violations are queued as stimulus
// is issued and a negedge monitor pops one entry for every err_o pulse.
module tb_wb_bfm_checker;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni = 1'b0;
    logic [31:0] wb_adr_i = 32'h0;
    logic [31:0] wb_dat_i = 32'h0;
    logic [3:0]  wb_sel_i = 4'h0;
    logic        wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0;
    logic [2:0]  wb_cti_i = 3'b000;
    logic [1:0]  wb_bte_i = 2'b00;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;
    logic        err_o;
    logic [3:0]  err_code_o;
    logic [31:0] err_adr_o;
    logic [7:0]  err_cnt_o;
    logic [15:0] rd_cnt_o, wr_cnt_o, burst_cnt_o;

    typedef struct {
        logic [3:0]  code;
        logic [31:0] adr;
        logic [7:0]  cnt;
    } exp_t;

    exp_t       err_q[$];
    int         nvec = 0;
    int         nfail = 0;
    logic [7:0] exp_err_cnt = 8'd0;

    wb_bfm_checker #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni), .wb_adr_i(wb_adr_i),
        .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_cti_i(wb_cti_i),
        .wb_bte_i(wb_bte_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .wb_rty_i(wb_rty_i), .err_o(err_o), .err_code_o(err_code_o),
        .err_adr_o(err_adr_o), .err_cnt_o(err_cnt_o), .rd_cnt_o(rd_cnt_o),
        .wr_cnt_o(wr_cnt_o), .burst_cnt_o(burst_cnt_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One bus cycle: drive, then let the DUT sample it on the next edge.
    task automatic drive(input logic cyc, input logic stb, input logic we, input logic [31:0] adr,
                         input logic [2:0] cti, input logic [1:0] bte,
                         input logic ack, input logic err, input logic rty);
        wb_cyc_i = cyc; wb_stb_i = stb; wb_we_i = we; wb_adr_i = adr;
        wb_dat_i = adr ^ 32'hA5A5_0000; wb_sel_i = 4'hF;
        wb_cti_i = cti; wb_bte_i = bte;
        wb_ack_i = ack; wb_err_i = err; wb_rty_i = rty;
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic beat(input logic we, input logic [31:0] adr, input logic [2:0] cti, input logic [1:0] bte);
        drive(1'b1, 1'b1, we, adr, cti, bte, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic expect_err(input logic [3:0] code, input logic [31:0] adr);
        exp_t e;
        exp_err_cnt = exp_err_cnt + 8'd1;
        e.code = code; e.adr = adr; e.cnt = exp_err_cnt;
        err_q.push_back(e);
    endtask

    task automatic drain(input string name);
        idle(2);
        check(name, err_q.size(), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " err_o"},       {31'd0, err_o}, 32'd0);
        check({tag, " err_code_o"},  {28'd0, err_code_o}, 32'd0);
        check({tag, " err_adr_o"},   err_adr_o, 32'd0);
        check({tag, " err_cnt_o"},   {24'd0, err_cnt_o}, 32'd0);
        check({tag, " rd_cnt_o"},    {16'd0, rd_cnt_o}, 32'd0);
        check({tag, " wr_cnt_o"},    {16'd0, wr_cnt_o}, 32'd0);
        check({tag, " burst_cnt_o"}, {16'd0, burst_cnt_o}, 32'd0);
    endtask

    // Monitor: every violation pulse must match the oldest queued expectation.
    always @(negedge wb_clk_i) begin
        if (err_o) begin
            if (err_q.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL unexpected_err: got code %0d adr 0x%0h, expected no pulse",
                         err_code_o, err_adr_o);
            end else begin
                exp_t e;
                e = err_q.pop_front();
                check("err_code", {28'd0, err_code_o}, {28'd0, e.code});
                check("err_adr",  err_adr_o, e.adr);
                check("err_cnt",  {24'd0, err_cnt_o}, {24'd0, e.cnt});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge wb_clk_i);
        #1;
        check_all_zero("reset");
        wb_rst_ni = 1'b1;
        idle(2);

        // Linear write burst.
        beat(1'b1, 32'h100, 3'b010, 2'b00);
        beat(1'b1, 32'h104, 3'b010, 2'b00);
        beat(1'b1, 32'h108, 3'b010, 2'b00);
        beat(1'b1, 32'h10C, 3'b111, 2'b00);
        drain("linear_q");
        check("linear wr_cnt", {16'd0, wr_cnt_o}, 32'd4);
        check("linear burst_cnt", {16'd0, burst_cnt_o}, 32'd1);
        check("linear err_cnt", {24'd0, err_cnt_o}, 32'd0);

        // Wrap4 read burst, legal sequence.
        beat(1'b0, 32'h10C, 3'b010, 2'b01);
        beat(1'b0, 32'h100, 3'b010, 2'b01);
        beat(1'b0, 32'h104, 3'b010, 2'b01);
        beat(1'b0, 32'h108, 3'b111, 2'b01);
        drain("wrap4_q");
        check("wrap4 rd_cnt", {16'd0, rd_cnt_o}, 32'd4);
        check("wrap4 burst_cnt", {16'd0, burst_cnt_o}, 32'd2);

        // Wrap4 with a bad second address, then tracking resumes from it.
        beat(1'b0, 32'h10C, 3'b010, 2'b01);
        expect_err(4'd5, 32'h110);
        beat(1'b0, 32'h110, 3'b010, 2'b01);
        beat(1'b0, 32'h114, 3'b111, 2'b01);
        drain("wrap4_bad_q");
        check("wrap4_bad rd_cnt", {16'd0, rd_cnt_o}, 32'd7);
        check("wrap4_bad burst_cnt", {16'd0, burst_cnt_o}, 32'd3);

        // cyc dropped inside a burst.
        beat(1'b1, 32'h200, 3'b010, 2'b00);
        expect_err(4'd7, 32'h0);
        idle(1);
        drain("cyc_drop_q");
        check("cyc_drop wr_cnt", {16'd0, wr_cnt_o}, 32'd5);
        check("cyc_drop burst_cnt", {16'd0, burst_cnt_o}, 32'd3);

        // ack and err together on a classic write.
        expect_err(4'd3, 32'h300);
        drive(1'b1, 1'b1, 1'b1, 32'h300, 3'b000, 2'b00, 1'b1, 1'b1, 1'b0);
        drain("multi_term_q");
        check("multi_term wr_cnt", {16'd0, wr_cnt_o}, 32'd5);

        // stb without cyc (with ack), then ack without stb, then reserved cti.
        expect_err(4'd1, 32'h400);
        drive(1'b0, 1'b1, 1'b0, 32'h400, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0);
        expect_err(4'd4, 32'h404);
        drive(1'b1, 1'b0, 1'b0, 32'h404, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0);
        expect_err(4'd7, 32'h500);
        beat(1'b1, 32'h500, 3'b011, 2'b00);
        idle(1);
        // Address change during a wait state.
        drive(1'b1, 1'b1, 1'b0, 32'h600, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
        expect_err(4'd2, 32'h604);
        drive(1'b1, 1'b1, 1'b0, 32'h604, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 32'h604, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0);
        drain("misc_q");
        check("misc wr_cnt", {16'd0, wr_cnt_o}, 32'd6);
        check("misc rd_cnt", {16'd0, rd_cnt_o}, 32'd8);

        // Stalled strobe for 40 cycles with TIMEOUT=16: a single report.
        expect_err(4'd6, 32'h700);
        for (int i = 0; i < 40; i++) drive(1'b1, 1'b1, 1'b0, 32'h700, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
        drain("timeout_q");
        check("timeout err_cnt", {24'd0, err_cnt_o}, 32'd8);
        check("timeout rd_cnt", {16'd0, rd_cnt_o}, 32'd8);

        // Reset pulse in the middle of a burst; checking restarts cleanly.
        beat(1'b1, 32'h800, 3'b010, 2'b00);
        beat(1'b1, 32'h804, 3'b010, 2'b00);
        wb_rst_ni = 1'b0;
        wb_adr_i = 32'h808; wb_ack_i = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_err_cnt = 8'd0;
        @(posedge wb_clk_i);
        #1;
        wb_rst_ni = 1'b1;
        beat(1'b1, 32'h808, 3'b010, 2'b00);
        beat(1'b1, 32'h80C, 3'b111, 2'b00);
        idle(1);
        beat(1'b1, 32'h900, 3'b010, 2'b00);
        beat(1'b1, 32'h904, 3'b010, 2'b00);
        beat(1'b1, 32'h908, 3'b010, 2'b00);
        beat(1'b1, 32'h90C, 3'b111, 2'b00);
        drain("after_reset_q");
        check("after_reset wr_cnt", {16'd0, wr_cnt_o}, 32'd6);
        check("after_reset burst_cnt", {16'd0, burst_cnt_o}, 32'd2);
        check("after_reset err_cnt", {24'd0, err_cnt_o}, 32'd0);
        check("after_reset rd_cnt", {16'd0, rd_cnt_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
